// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - RV32M divide/remainder sequencer for external multi-cycle dividers
// Holds operands for the dividers, stalls EX while they count, and short-circuits div-by-zero and overflow.
module div_seq_ctrl #(
    parameter int DIV_LATENCY = 8,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_vld,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] src0,
    input  logic [XLEN-1:0] src1,
    input  logic            flush,
    output logic [XLEN-1:0] div_numer,
    output logic [XLEN-1:0] div_denom,
    output logic            div_sgn,
    input  logic [XLEN-1:0] signed_quo,
    input  logic [XLEN-1:0] signed_rem,
    input  logic [XLEN-1:0] unsigned_quo,
    input  logic [XLEN-1:0] unsigned_rem,
    output logic            stall,
    output logic            rsp_vld,
    output logic [XLEN-1:0] rsp_rslt,
    output logic            busy
);
    localparam int CW = $clog2(DIV_LATENCY + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            rem_sel_q;
    logic [XLEN-1:0] numer_q;
    logic [XLEN-1:0] denom_q;
    logic            sgn_q;
    logic [XLEN-1:0] rslt_q;

    logic            accept;
    logic            div_zero;
    logic            sgn_ovf;
    logic [XLEN-1:0] special_rslt;
    logic [XLEN-1:0] div_rslt;

    assign accept   = (state_q == S_IDLE) && req_vld && !flush;
    assign div_zero = (src1 == '0);
    assign sgn_ovf  = !req_op[0] && (src0 == MIN_NEG) && (src1 == ALL_ONE);

    // Zero-divisor results are the same for signed and unsigned ops.
    always_comb begin
        special_rslt = '0;
        if (div_zero)
            special_rslt = req_op[1] ? src0 : ALL_ONE;
        else
            special_rslt = req_op[1] ? '0 : MIN_NEG;
    end

    always_comb begin
        div_rslt = '0;
        case ({sgn_q, rem_sel_q})
            2'b10:   div_rslt = signed_quo;
            2'b11:   div_rslt = signed_rem;
            2'b00:   div_rslt = unsigned_quo;
            default: div_rslt = unsigned_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_sel_q <= 1'b0;
            numer_q   <= '0;
            denom_q   <= '0;
            sgn_q     <= 1'b0;
            rslt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        numer_q   <= src0;
                        denom_q   <= src1;
                        sgn_q     <= ~req_op[0];
                        rem_sel_q <= req_op[1];
                        if (div_zero || sgn_ovf) begin
                            rslt_q  <= special_rslt;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q   <= CW'(DIV_LATENCY);
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            rslt_q  <= div_rslt;
                            state_q <= S_DONE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign div_numer = numer_q;
    assign div_denom = denom_q;
    assign div_sgn   = sgn_q;
    assign rsp_rslt  = rslt_q;
    assign busy      = (state_q != S_IDLE);
    // Flush must suppress the response in the very cycle it arrives.
    assign rsp_vld   = (state_q == S_DONE) && !flush;
    assign stall     = accept || ((state_q == S_WAIT) && !flush);

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - randomized and directed bench for div_seq_ctrl against a cycle-count reference model
module tb_div_seq_ctrl;
    localparam int L = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_vld = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] src0 = '0;
    logic [31:0] src1 = '0;
    logic        flush = 1'b0;
    logic [31:0] div_numer, div_denom;
    logic        div_sgn;
    logic [31:0] signed_quo, signed_rem, unsigned_quo, unsigned_rem;
    logic        stall, rsp_vld, busy;
    logic [31:0] rsp_rslt;

    always #5 clk = ~clk;

    div_seq_ctrl #(.DIV_LATENCY(L), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_op(req_op),
        .src0(src0), .src1(src1), .flush(flush),
        .div_numer(div_numer), .div_denom(div_denom), .div_sgn(div_sgn),
        .signed_quo(signed_quo), .signed_rem(signed_rem),
        .unsigned_quo(unsigned_quo), .unsigned_rem(unsigned_rem),
        .stall(stall), .rsp_vld(rsp_vld), .rsp_rslt(rsp_rslt), .busy(busy)
    );

    // Ideal dividers; the degenerate cases return junk since the sequencer must bypass them.
    always_comb begin
        signed_quo   = 32'hDEAD_BEEF;
        signed_rem   = 32'hDEAD_BEEF;
        unsigned_quo = 32'hDEAD_BEEF;
        unsigned_rem = 32'hDEAD_BEEF;
        if (div_denom != 0) begin
            unsigned_quo = div_numer / div_denom;
            unsigned_rem = div_numer % div_denom;
            if (!(div_numer == 32'h8000_0000 && div_denom == 32'hFFFF_FFFF)) begin
                signed_quo = $signed(div_numer) / $signed(div_denom);
                signed_rem = $signed(div_numer) % $signed(div_denom);
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (b == 0)
            r = op[1] ? a : 32'hFFFF_FFFF;
        else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            r = op[1] ? 32'h0 : 32'h8000_0000;
        else if (!op[0])
            r = op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        else
            r = op[1] ? (a % b) : (a / b);
        return r;
    endfunction

    // Reference model: one pending op with the cycle its response is due.
    int          cyc = 0;
    bit          chk_en = 0;
    bit          m_pend = 0;
    int          m_rsp_at = 0;
    logic [31:0] m_res = '0, m_out = '0, m_numer = '0, m_denom = '0;
    logic        m_sgn = 1'b0;
    bit          seen_vld;
    logic [31:0] seen_rslt;

    task automatic step(input logic r, input logic v, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b, input logic f);
        logic exp_stall, exp_vld;
        rst = r; req_vld = v; req_op = o; src0 = a; src1 = b; flush = f;
        @(negedge clk);
        exp_stall = m_pend ? (!f && cyc < m_rsp_at) : (v && !f);
        exp_vld   = m_pend && !f && cyc == m_rsp_at;
        if (chk_en) begin
            check_eq("stall", 32'(stall), 32'(exp_stall));
            check_eq("rsp_vld", 32'(rsp_vld), 32'(exp_vld));
            check_eq("busy", 32'(busy), 32'(m_pend));
            check_eq("rsp_rslt", rsp_rslt, m_out);
            check_eq("div_numer", div_numer, m_numer);
            check_eq("div_denom", div_denom, m_denom);
            check_eq("div_sgn", 32'(div_sgn), 32'(m_sgn));
        end
        seen_vld  = rsp_vld;
        seen_rslt = rsp_rslt;
        if (r) begin
            m_pend = 0; m_out = '0; m_numer = '0; m_denom = '0; m_sgn = 1'b0;
        end else if (m_pend) begin
            if (f) m_pend = 0;
            else begin
                if (cyc == m_rsp_at - 1) m_out = m_res;
                if (cyc == m_rsp_at) m_pend = 0;
            end
        end else if (v && !f) begin
            m_numer = a; m_denom = b; m_sgn = ~o[0];
            m_res = ref_res(o, a, b);
            m_pend = 1;
            if (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
                m_rsp_at = cyc + 1;
                m_out = m_res;
            end else
                m_rsp_at = cyc + L + 1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 2'b00, '0, '0, 0);
    endtask

    // One request, then wait (bounded) for its response and check value and latency.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int k;
        step(0, 1, o, a, b, 0);
        for (k = 1; k <= 20; k++) begin
            step(0, 0, 2'b00, '0, '0, 0);
            if (seen_vld) break;
        end
        check_eq("latency", 32'(k), 32'(exp_lat));
        check_eq("result", seen_rslt, exp);
    endtask

    initial begin
        step(1, 0, 2'b00, '0, '0, 0);
        chk_en = 1;
        step(1, 1, 2'b01, 32'h1234, 32'h5, 0);
        idle(2);

        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, L + 1);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, L + 1);
        run_op(2'b01, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, L + 1);
        run_op(2'b11, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, L + 1);
        run_op(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op(2'b10, 32'd5, 32'd0, 32'd5, 1);
        run_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op(2'b11, 32'd5, 32'd0, 32'd5, 1);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, L + 1);

        // Flush mid-wait, then a fresh op two cycles later.
        step(0, 1, 2'b00, 32'd100, 32'd7, 0);
        idle(3);
        step(0, 0, 2'b00, '0, '0, 1);
        idle(1);
        run_op(2'b00, 32'd100, 32'd7, 32'd14, L + 1);

        // Reset mid-wait, then requests held high back to back.
        step(0, 1, 2'b11, 32'd77, 32'd9, 0);
        idle(2);
        step(1, 1, 2'b11, 32'd77, 32'd9, 0);
        idle(3);
        for (int i = 0; i < 40; i++)
            step(0, 1, 2'(i), 32'd1000 + 32'(i), (i % 5 == 0) ? 32'd0 : 32'(i + 3), 0);
        idle(L + 2);

        for (int i = 0; i < 1500; i++) begin
            logic        r, v, f;
            logic [1:0]  o;
            logic [31:0] a, b;
            r = ($urandom % 200) == 0;
            f = ($urandom % 25) == 0;
            v = ($urandom % 3) != 0;
            o = 2'($urandom);
            a = ($urandom % 8 == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom % 8)
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom % 16);
                default: b = $urandom;
            endcase
            step(r, v, o, a, b, f);
        end
        idle(L + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
